// File: rtl/stim_pkg.sv
// Shared definitions for the stimulus player: the controller state encoding
// and the layout of a program word (stimulus in the low bits, hold count
// above it, observation flag in the MSB).
package stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PLAY  = 2'd2
    } state_e;

    // The stimulus field always starts at bit 0 of a program word.
    localparam int STIM_LSB = 0;

    // Default field widths, matching the default player configuration.
    localparam int DEF_DATA_W = 2;
    localparam int DEF_HOLD_W = 4;

    // The hold field sits directly above the stimulus field.
    function automatic int holdLsb(input int dataW);
        return dataW;
    endfunction

    // The observation flag is the MSB, directly above the hold field.
    function automatic int obsBit(input int dataW, input int holdW);
        return dataW + holdW;
    endfunction

    // Total width of one program word.
    function automatic int wordW(input int dataW, input int holdW);
        return dataW + holdW + 1;
    endfunction

endpackage

// File: rtl/stim_ram.sv
// Program store for the stimulus player: one write port, one read port,
// registered read data (one-cycle latency). Contents survive reset.
module stim_ram
    import stim_pkg::*;
#(
    parameter int WIDTH  = wordW(DEF_DATA_W, DEF_HOLD_W),
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdData_q;

    // Write when asked and always read the addressed word into the output register.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rdData_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rdData_q;

endmodule

// File: rtl/stim_player.sv
// Stimulus player: walks a stored program, presenting each word's stimulus
// and observation flag for (hold+1) cycles, optionally looping. The RAM read
// register is the presentation register, so the next word's address is issued
// in the last cycle of the current word and words follow without gaps.
module stim_player
    import stim_pkg::*;
#(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 1024,
    parameter int HOLD_W = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W+HOLD_W:0]   wr_data,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     loop_en,
    input  logic [ADDR_W:0]          prog_len,
    output logic [DATA_W-1:0]        stim,
    output logic                     obs,
    output logic [ADDR_W-1:0]        pc,
    output logic                     busy,
    output logic                     done,
    output logic                     step,
    output logic [7:0]               pass_cnt
);

    localparam int              WORD_W   = wordW(DATA_W, HOLD_W);
    localparam int              HOLD_LSB = holdLsb(DATA_W);
    localparam int              OBS_BIT  = obsBit(DATA_W, HOLD_W);
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);

    state_e              state_q;
    logic [HOLD_W-1:0]   hcnt_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;
    logic [ADDR_W:0]     len_q;
    logic                loop_q;
    logic [7:0]          pass_q;
    logic                busy_q;
    logic                done_q;
    logic                step_q;

    logic [WORD_W-1:0]   ramRdata;
    logic [ADDR_W-1:0]   rdAddr;
    logic                wrAccept;
    logic [ADDR_W:0]     clampedLen;
    logic [DATA_W-1:0]   curStim;
    logic [HOLD_W-1:0]   curHold;
    logic                curObs;
    logic                expire;
    logic                lastWord;

    assign curStim    = ramRdata[STIM_LSB +: DATA_W];
    assign curHold    = ramRdata[HOLD_LSB +: HOLD_W];
    assign curObs     = ramRdata[OBS_BIT];
    assign expire     = (state_q == ST_PLAY) && (hcnt_q == curHold);
    assign lastWord   = ({1'b0, pc_q} == (len_q - (ADDR_W+1)'(1)));
    assign pc_d       = lastWord ? '0 : pc_q + ADDR_W'(1);
    assign wrAccept   = wr_en && (state_q == ST_IDLE) && ({1'b0, wr_addr} < DEPTH_L);
    assign clampedLen = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;

    // Read address: word 0 while fetching, the following word in a word's last cycle, else hold the current one.
    always_comb begin
        rdAddr = pc_q;
        if (state_q == ST_FETCH) begin
            rdAddr = '0;
        end else if (expire) begin
            rdAddr = pc_d;
        end
    end

    stim_ram #(
        .WIDTH  (WORD_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock     (clock),
        .wr_en_i   (wrAccept),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (rdAddr),
        .rd_data_o (ramRdata)
    );

    // Playback controller: abort beats everything, then word expiry decides advance, wrap or finish.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            pc_q    <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            pass_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            step_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!abort && start && (prog_len != '0)) begin
                        state_q <= ST_FETCH;
                        busy_q  <= 1'b1;
                        loop_q  <= loop_en;
                        len_q   <= clampedLen;
                        pc_q    <= '0;
                        pass_q  <= '0;
                        hcnt_q  <= '0;
                    end
                end
                ST_FETCH: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_PLAY;
                        step_q  <= 1'b1;
                        hcnt_q  <= '0;
                    end
                end
                ST_PLAY: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (expire) begin
                        hcnt_q <= '0;
                        if (lastWord && !loop_q) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            pc_q   <= pc_d;
                            step_q <= 1'b1;
                            if (lastWord && (pass_q != 8'hFF)) begin
                                pass_q <= pass_q + 8'd1;
                            end
                        end
                    end else begin
                        hcnt_q <= hcnt_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign stim     = (state_q == ST_PLAY) ? curStim : '0;
    assign obs      = (state_q == ST_PLAY) ? curObs : 1'b0;
    assign pc       = pc_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step     = step_q;
    assign pass_cnt = pass_q;

endmodule

// File: doc/stim_player.md
STIM_PLAYER -- requirements
Module: stim_player

Interface
REQ-001 SHALL have parameter DATA_W, default 2: width of the stimulus vector driven to the DUT.
REQ-002 SHALL have parameter DEPTH, default 1024: number of program words.
REQ-003 SHALL have parameter HOLD_W, default 4: width of the per-word hold field.
REQ-004 SHALL have parameter ADDR_W, default $clog2(DEPTH): program address width.
REQ-005 SHALL have port clock  in  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port wr_en  in  1  program write strobe.
REQ-008 SHALL have port wr_addr  in  ADDR_W  program write address.
REQ-009 SHALL have port wr_data  in  DATA_W+HOLD_W+1  program word: [DATA_W-1:0] stimulus, [DATA_W+HOLD_W-1:DATA_W] hold, MSB obs.
REQ-010 SHALL have port start  in  1  begin playback, sampled in IDLE only.
REQ-011 SHALL have port abort  in  1  terminate playback.
REQ-012 SHALL have port loop_en  in  1  replay continuously; latched at start.
REQ-013 SHALL have port prog_len  in  ADDR_W+1  number of words to play; latched at start.
REQ-014 SHALL have port stim  out  DATA_W  current stimulus vector.
REQ-015 SHALL have port obs  out  1  observation flag of the current word.
REQ-016 SHALL have port pc  out  ADDR_W  address of the word currently presented.
REQ-017 SHALL have port busy  out  1  high in FETCH and PLAY.
REQ-018 SHALL have port done  out  1  one-cycle pulse on normal completion.
REQ-019 SHALL have port step  out  1  one-cycle pulse in the first cycle of each presented word.
REQ-020 SHALL have port pass_cnt  out  8  completed passes in loop mode; saturates at 255.

Function
REQ-021 FSM states SHALL be IDLE, FETCH and PLAY.
REQ-022 IDLE SHALL go to FETCH on start=1 with prog_len!=0, latching loop_en, and latching prog_len clamped to DEPTH.
REQ-023 start with prog_len=0, and start outside IDLE, SHALL be ignored.
REQ-024 FETCH SHALL last exactly one cycle, issuing a synchronous read of address 0; the first word SHALL appear on stim/obs on the second rising edge after start is sampled.
REQ-025 Each word SHALL remain on stim/obs for hold+1 cycles.
REQ-026 The next word SHALL be prefetched so that consecutive words are contiguous, with no bubble cycles, even when hold=0.
REQ-027 After the last word (pc=len-1) expires with loop_en latched, pc SHALL wrap to 0 without a bubble, and pass_cnt SHALL increment.
REQ-028 After the last word expires without loop_en, the FSM SHALL return to IDLE, done SHALL pulse for that one cycle, and stim/obs SHALL be 0.
REQ-029 abort SHALL force IDLE on the next edge, zeroing stim/obs, without a done pulse; abort SHALL take priority over all other events, including final-word expiry in the same cycle.
REQ-030 In IDLE, stim, obs, step and busy SHALL be 0; pc and pass_cnt SHALL hold their last values.
REQ-031 pass_cnt SHALL clear on each accepted start.
REQ-032 wr_en SHALL write the program memory only in IDLE; writes while busy SHALL be dropped.
REQ-033 Writes with wr_addr >= DEPTH SHALL be dropped.

Reset
REQ-034 Reset SHALL force IDLE and zero stim, obs, pc, busy, done, step, pass_cnt and the latched controls.
REQ-035 Program memory contents SHALL NOT be cleared by reset.
REQ-036 Reset asserted mid-playback SHALL take effect asynchronously; playback SHALL NOT resume after reset deasserts.

Structure
REQ-037 Package stim_pkg SHALL hold the state enum and the field-offset/width localparams of the program word.
REQ-038 Program storage SHALL be a sub-module stim_ram: simple dual-port, synchronous read with 1-cycle latency, no reset.

Verification
REQ-039 DATA_W=2, words {obs0,h0,01},{obs1,h2,10},{obs0,h0,11}, len=3, loop off: after start, stim SHALL read 01,10,10,10,11; obs SHALL be high for the three 10 cycles; step SHALL pulse 3 times; done SHALL pulse once; total busy cycles SHALL be 6.
REQ-040 Same program with loop_en=1, run 15 cycles after the first word appears, then abort: the stim sequence SHALL repeat without gaps, pass_cnt SHALL be 3, and done SHALL stay low.
REQ-041 start with prog_len=0, and a second start while busy: no state change, busy SHALL stay as before.
REQ-042 wr_en to address 1 during playback, then a replay: the original word 1 SHALL be presented.
REQ-043 reset asserted in the hold of word 1: all outputs SHALL be 0 immediately; after release, busy SHALL remain 0 and the program SHALL be intact on the next start.
REQ-044 DEPTH=4 with prog_len=7: exactly 4 words SHALL be played.
